conv_layer_sequencer: RTL
=========================

Name: conv_layer_sequencer

Overview:
- Sequences one valid 3x3 convolution layer through buffer_router and the systolic array.
- Streams an ifmap into the router register file over a valid/ready input, then pulses the router start.
- Waits for router completion and for all OFMAP writeback beats, then reports done or error.
- Sits between the host/DMA stream and buffer_router (drives wr_*, ctrl_start; observes flag_done, ofmap_valid_i).

Parameters:
- dataSize, 8, ifmap element width.
- numRegister, 256, router register-file depth; nAddress = $clog2(numRegister).
- kernelWidth, 3, convolution kernel side.
- nOfmapElements, 3, OFMAP elements written per writeback beat.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- cfg_ifmap_width  in  16  square ifmap side; sampled on accepted start.
- start_i  in  1  begin layer; accepted only in S_IDLE.
- busy_o  out  1  high in every state except S_IDLE.
- done_o  out  1  one-cycle pulse on layer completion.
- err_o  out  1  sticky error; cleared on next accepted start.
- in_data  in  dataSize  ifmap element stream.
- in_valid  in  1  stream valid.
- in_ready  out  1  stream ready.
- buf_wr_data  out  dataSize  to router wr_data.
- buf_wr_addr  out  nAddress  to router wr_addr.
- buf_wr_en  out  1  to router wr_en.
- router_start  out  1  to router ctrl_start.
- router_done  in  1  from router flag_done.
- ofmap_valid_i  in  1  tap of the router OFMAP writeback valid.

Behaviour:
- Reset: state S_IDLE, all counters 0, all outputs 0 (including err_o). Reset mid-operation aborts immediately; no partial done_o.
- Derived values, computed in 32-bit unsigned arithmetic from the latched width W:
  - npix = W*W
  - ow = W - kernelWidth + 1
  - beats = ceil(ow*ow / nOfmapElements)
- Config check on accepted start:
  - Error if W < kernelWidth or npix + beats*nOfmapElements > numRegister.
  - On error: err_o=1, done_o pulses the next cycle, return to S_IDLE; no writes, no router_start.
- States:
  - S_IDLE: in_ready=0. start_i=1 latches W, clears err_o and counters, goes to S_LOAD, or to S_DONE if the config check fails. start_i while busy_o=1 is ignored.
  - S_LOAD: in_ready=1.
    - A transfer happens when in_valid&in_ready. In that same cycle, combinationally: buf_wr_en=1, buf_wr_addr=load_cnt, buf_wr_data=in_data. Zero latency.
    - load_cnt increments per transfer.
    - On the transfer with load_cnt==npix-1, go to S_START.
    - in_valid gaps stall with no writes.
  - S_START: router_start=1 for exactly one cycle; in_ready=0; go to S_COMPUTE.
  - S_COMPUTE: wait for router_done. On router_done go to S_DRAIN if beat_cnt (including this cycle's beat) < beats, else to S_DONE.
  - S_DRAIN: wait until beat_cnt reaches beats, then go to S_DONE.
  - S_DONE: done_o=1 for one cycle, then go to S_IDLE.
- Beat counting:
  - beat_cnt increments on ofmap_valid_i in S_COMPUTE and S_DRAIN only, including a beat coincident with router_done.
  - ofmap_valid_i in S_IDLE, S_LOAD or S_START, or a beat beyond beats, sets err_o. The layer still completes normally.
- buf_wr_en is never asserted outside S_LOAD. router_start is never asserted outside S_START.

Decomposition:
- Shared package conv_pkg:
  - typedef enum logic [2:0] seq_state_t {S_IDLE, S_LOAD, S_START, S_COMPUTE, S_DRAIN, S_DONE}.
  - Function ofmap_beats(width, kernelWidth, nOfmapElements) for reuse by testbench and router.
- Single module. Config-check/derived-value logic may be split into sub-module conv_cfg_check (combinational, 32-bit).

Test Plan:
- W=5, continuous in_valid -> 25 writes, addr 0..24, data matches stream; router_start one cycle after the addr-24 write. Model router returns done plus 3 ofmap beats -> done_o pulse once, err_o=0, busy_o low after.
- W=5, in_valid toggling every other cycle -> still exactly 25 writes in order; no write on invalid cycles; same completion.
- W=2 -> err_o=1, done_o the cycle after start, zero buf_wr_en and router_start. W=16 (256+198>256) -> same error behaviour. W=10 (100+66<=256) -> accepted, 22 beats expected.
- W=5, router_done with 1 beat so far, remaining 2 beats 4 and 7 cycles later -> S_DRAIN entered; done_o one cycle after the third beat. Variant: third beat coincident with router_done -> straight to S_DONE.
- Extra 4th ofmap beat, or ofmap_valid_i during S_LOAD -> err_o=1 sticky and done_o still pulses; next start clears err_o.
- nrst low mid-S_LOAD at load_cnt=10 -> all outputs 0, state S_IDLE. New start with W=5 -> writes restart at addr 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, layer geometry constants and the OFMAP beat-count helper for the
// conv layer sequencer and its neighbours.
package conv_pkg;

  localparam int dataSize       = 8;
  localparam int numRegister    = 256;
  localparam int nAddress       = $clog2(numRegister);
  localparam int kernelWidth    = 3;
  localparam int nOfmapElements = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  // Writeback beats for a valid convolution of a square ifmap; 0 when the kernel does not fit.
  function automatic logic [31:0] ofmap_beats(input logic [31:0] width,
                                               input logic [31:0] kw,
                                               input logic [31:0] ne);
    logic [31:0] ow;
    ow = 32'd0;
    if (width < kw || ne == 32'd0) return 32'd0;
    ow = width - kw + 32'd1;
    return (ow * ow + ne - 32'd1) / ne;
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Ifmap stream plus router-side write/control signals between the sequencer and its environment.
interface conv_layer_sequencer_if
  import conv_pkg::*;
#(
  parameter int DATA_W = dataSize,
  parameter int ADDR_W = nAddress
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] buf_wr_data;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic              buf_wr_en;
  logic              router_start;
  logic              router_done;
  logic              ofmap_valid_i;

  modport master (
    input  in_data, in_valid, router_done, ofmap_valid_i,
    output in_ready, buf_wr_data, buf_wr_addr, buf_wr_en, router_start
  );

  modport slave (
    output in_data, in_valid, router_done, ofmap_valid_i,
    input  in_ready, buf_wr_data, buf_wr_addr, buf_wr_en, router_start
  );
endinterface

// File: rtl/conv_cfg_check.sv
// Combinational layer geometry: pixel count, writeback beats and the register-file fit check.
module conv_cfg_check
  import conv_pkg::*;
(
  input  logic [15:0] width,
  output logic [31:0] npix,
  output logic [31:0] beats,
  output logic        cfg_err
);
  logic [31:0] w32;
  logic [31:0] need;

  always_comb begin
    w32   = {16'd0, width};
    npix  = w32 * w32;
    beats = ofmap_beats(w32, 32'(kernelWidth), 32'(nOfmapElements));
    need  = npix + beats * 32'(nOfmapElements);
    // npix is checked on its own so a wrapped sum can never pass for a huge width
    cfg_err = (w32 < 32'(kernelWidth)) || (npix > 32'(numRegister)) ||
              (need > 32'(numRegister));
  end
endmodule

// File: rtl/conv_layer_sequencer.sv
// Loads one ifmap into the router register file, kicks the router and waits for
// completion plus all OFMAP writeback beats.
//
// state     | meaning
// S_IDLE    | waiting for start_i; config checked on acceptance
// S_LOAD    | streaming ifmap elements into the register file
// S_START   | one-cycle router_start pulse
// S_COMPUTE | waiting for router_done, counting writeback beats
// S_DRAIN   | router done, waiting for remaining writeback beats
// S_DONE    | one-cycle done_o pulse
module conv_layer_sequencer
  import conv_pkg::*;
(
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [15:0]                   cfg_ifmap_width,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  conv_layer_sequencer_if.master        bus
);
  seq_state_t          state, state_nxt;
  logic [15:0]         width_q, width_sel;
  logic [nAddress-1:0] load_cnt;
  logic [31:0]         beat_cnt, beat_nxt, npix, beats;
  logic                cfg_err, last_load, beat_fire, stray_beat, extra_beat;

  // In idle the check sees the live config so the start decision is made in the same cycle
  assign width_sel = (state == S_IDLE) ? cfg_ifmap_width : width_q;

  conv_cfg_check u_cfg (
    .width   (width_sel),
    .npix    (npix),
    .beats   (beats),
    .cfg_err (cfg_err)
  );

  assign last_load  = ({{(32-nAddress){1'b0}}, load_cnt} == npix - 32'd1);
  assign beat_fire  = bus.ofmap_valid_i && (state == S_COMPUTE || state == S_DRAIN);
  assign beat_nxt   = beat_cnt + {31'd0, beat_fire};
  assign stray_beat = bus.ofmap_valid_i && (state == S_LOAD || state == S_START);
  assign extra_beat = beat_fire && (beat_cnt >= beats);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    busy_o           = 1'b1;
    done_o           = 1'b0;
    bus.in_ready     = 1'b0;
    bus.buf_wr_en    = 1'b0;
    bus.buf_wr_addr  = load_cnt;
    bus.buf_wr_data  = bus.in_data;
    bus.router_start = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = cfg_err ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.buf_wr_en = 1'b1;
          if (last_load) state_nxt = S_START;
        end
      end
      S_START: begin
        bus.router_start = 1'b1;
        state_nxt        = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (bus.router_done) state_nxt = (beat_nxt < beats) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (beat_nxt >= beats) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      width_q  <= 16'd0;
      load_cnt <= '0;
      beat_cnt <= 32'd0;
      err_o    <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start_i) begin
        width_q  <= cfg_ifmap_width;
        load_cnt <= '0;
        beat_cnt <= 32'd0;
        err_o    <= cfg_err;
      end else if (bus.ofmap_valid_i) begin
        err_o <= 1'b1;
      end
    end else begin
      if (bus.buf_wr_en) load_cnt <= load_cnt + 1'b1;
      beat_cnt <= beat_nxt;
      if (stray_beat || extra_beat) err_o <= 1'b1;
    end
  end
endmodule
